seq_generator: RTL and testbench

- Serial pattern transmitter; the transmit-side counterpart of the serial sequence detector.
- Accepts parallel words (data plus bit count) over a valid/ready handshake and emits them one bit per clock, MSB of the field first.
- Drives the detector's serial input for self-checking loopback benches; usable as a generic serializer elsewhere in the design.

---
 rtl/seq_gen_pkg.sv | 15 +
 rtl/seq_gen_skid.sv | 37 +++
 rtl/seq_generator.sv | 126 ++++++++++++
 tb/tb_seq_generator.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_gen_pkg.sv
// Shared types and sizing helpers for the serial pattern generator.
package seq_gen_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  // Bits needed to hold the values 0..max_val (never less than one).
  function automatic int cnt_bits(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/seq_gen_skid.sv
// One-entry pending slot in front of the shifter; accepts a word on the same edge the slot drains.
module seq_gen_skid
  import seq_gen_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LW    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic [LW-1:0]    in_len,
  input  logic             in_valid,
  input  logic             load_now,
  output logic             in_ready,
  output logic             pend_valid,
  output logic [WIDTH-1:0] pend_data,
  output logic [LW-1:0]    pend_len
);

  // load_now depends only on registered state, so in_ready never sees in_valid.
  assign in_ready = reset && (!pend_valid || load_now);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_valid <= 1'b0;
      pend_data  <= '0;
      pend_len   <= '0;
    end else if (in_valid && in_ready) begin
      pend_valid <= 1'b1;
      pend_data  <= in_data;
      pend_len   <= in_len;
    end else if (load_now) begin
      pend_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/seq_generator.sv
// Serializer: takes (data, len) words over valid/ready and emits them MSB-of-field first, one bit per clock.
//
// state | meaning
// IDLE  | shifter empty; loads the pending word if there is one
// SHIFT | a payload bit is on dout; cnt = bits left including the one shown
// GAP   | inter-word idle time, gap_cnt cycles remaining
module seq_generator
  import seq_gen_pkg::*;
#(
  parameter int   WIDTH      = 8,
  parameter int   GAP_CYCLES = 0,
  parameter logic IDLE_LEVEL = 1'b0,
  localparam int  LW         = cnt_bits(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic [LW-1:0]    in_len,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             dout,
  output logic             dout_valid,
  output logic             done,
  output logic             len_err,
  output logic             busy
);

  localparam int GW = cnt_bits(GAP_CYCLES);

  state_t           state, state_nx;
  logic             pend_valid;
  logic [WIDTH-1:0] pend_data;
  logic [LW-1:0]    pend_len;
  logic             load_now;
  logic             len_ok;
  logic             last_bit;
  logic             gap_last;
  logic [WIDTH-1:0] aligned;
  logic [WIDTH-1:0] shreg;
  logic [LW-1:0]    cnt;
  logic [GW-1:0]    gap_cnt;

  seq_gen_skid #(
    .WIDTH(WIDTH),
    .LW   (LW)
  ) u_skid (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_len    (in_len),
    .in_valid  (in_valid),
    .load_now  (load_now),
    .in_ready  (in_ready),
    .pend_valid(pend_valid),
    .pend_data (pend_data),
    .pend_len  (pend_len)
  );

  assign len_ok   = (pend_len != '0) && (pend_len <= LW'(WIDTH));
  assign aligned  = pend_data << (LW'(WIDTH) - pend_len);
  assign last_bit = (cnt == LW'(1));
  assign gap_last = (gap_cnt == GW'(1));
  assign busy     = pend_valid || (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    load_now = 1'b0;
    case (state)
      IDLE: load_now = pend_valid;
      SHIFT: begin
        if (last_bit) begin
          if (GAP_CYCLES > 0)  state_nx = GAP;
          else if (pend_valid) load_now = 1'b1;
          else                 state_nx = IDLE;
        end
      end
      GAP: begin
        if (gap_last) begin
          if (pend_valid) load_now = 1'b1;
          else            state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
    // An illegal word is dropped without bits or gap, leaving the shifter idle.
    if (load_now) state_nx = len_ok ? SHIFT : IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg      <= '0;
      cnt        <= '0;
      gap_cnt    <= '0;
      dout       <= IDLE_LEVEL;
      dout_valid <= 1'b0;
      done       <= 1'b0;
      len_err    <= 1'b0;
    end else begin
      dout       <= IDLE_LEVEL;
      dout_valid <= 1'b0;
      done       <= 1'b0;
      len_err    <= load_now && !len_ok;
      if (load_now && len_ok) begin
        dout       <= aligned[WIDTH-1];
        shreg      <= aligned << 1;
        cnt        <= pend_len;
        dout_valid <= 1'b1;
        done       <= (pend_len == LW'(1));
      end else if (state == SHIFT && !last_bit) begin
        dout       <= shreg[WIDTH-1];
        shreg      <= shreg << 1;
        cnt        <= cnt - 1'b1;
        dout_valid <= 1'b1;
        done       <= (cnt == LW'(2));
      end
      if (state == SHIFT && state_nx == GAP) gap_cnt <= GW'(GAP_CYCLES);
      else if (state == GAP)                 gap_cnt <= gap_cnt - 1'b1;
    end
  end

endmodule

// File: tb/tb_seq_generator.sv
// Bench for seq_generator: a streaming instance (no gap) and a gapped instance (gap 2, idle level 1).
module tb_seq_generator;
  localparam int WIDTH = 8;
  localparam int LW    = $clog2(WIDTH + 1);
  localparam int GAP1  = 2;

  typedef struct { int u; int cyc; logic b; logic d; } obs_t;
  typedef struct { logic b; logic d; } eb_t;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [WIDTH-1:0] in_data [2];
  logic [LW-1:0]    in_len  [2];
  logic [1:0]       in_valid;
  logic [1:0]       in_ready, dout, dout_valid, done, len_err, busy;
  logic [1:0]       idle_lv = 2'b10;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   lerr_cnt [2];
  int   idle_bad [2];
  int   exp_err  = 0;
  obs_t obs[$];
  eb_t  exp_q[$];

  seq_generator #(.WIDTH(WIDTH), .GAP_CYCLES(0), .IDLE_LEVEL(1'b0)) g0 (
    .clk(clk), .reset(reset), .in_data(in_data[0]), .in_len(in_len[0]),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .dout(dout[0]),
    .dout_valid(dout_valid[0]), .done(done[0]), .len_err(len_err[0]), .busy(busy[0]));

  seq_generator #(.WIDTH(WIDTH), .GAP_CYCLES(GAP1), .IDLE_LEVEL(1'b1)) g2 (
    .clk(clk), .reset(reset), .in_data(in_data[1]), .in_len(in_len[1]),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .dout(dout[1]),
    .dout_valid(dout_valid[1]), .done(done[1]), .len_err(len_err[1]), .busy(busy[1]));

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  // Recorder: logs every payload bit with the edge count that produced it.
  always @(negedge clk) begin
    if (reset) begin
      for (int u = 0; u < 2; u++) begin
        if (dout_valid[u]) begin
          obs_t o;
          o.u = u; o.cyc = cyc; o.b = dout[u]; o.d = done[u];
          obs.push_back(o);
        end else if (dout[u] !== idle_lv[u] || done[u] !== 1'b0) begin
          idle_bad[u]++;
        end
        if (len_err[u]) lerr_cnt[u]++;
      end
    end
  end

  // Reference: a legal word yields its len low bits MSB first, done on the last.
  function automatic void model_word(input logic [WIDTH-1:0] d, input int l);
    eb_t e;
    if (l < 1 || l > WIDTH) begin
      exp_err++;
      return;
    end
    for (int i = l - 1; i >= 0; i--) begin
      e.b = d[i]; e.d = (i == 0);
      exp_q.push_back(e);
    end
  endfunction

  task automatic clear_all(input int u);
    obs.delete(); exp_q.delete();
    exp_err = 0; lerr_cnt[u] = 0; idle_bad[u] = 0;
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge with acc = that edge's count.
  task automatic send(input int u, input logic [WIDTH-1:0] d, input int l, output int acc);
    int t = 0;
    in_data[u] = d; in_len[u] = LW'(l); in_valid[u] = 1'b1;
    while (in_ready[u] !== 1'b1 && t < 200) begin @(negedge clk); t++; end
    @(posedge clk);
    @(negedge clk);
    acc = cyc;
    in_valid[u] = 1'b0;
    n_checks++;
    if (t >= 200) begin n_fail++; $display("FAIL send_timeout u=%0d got no in_ready want in_ready within 200 cycles", u); end
  endtask

  task automatic wait_idle(input int u);
    int t = 0;
    while ((busy[u] !== 1'b0 || dout_valid[u] !== 1'b0) && t < 300) begin @(negedge clk); t++; end
    repeat (4) @(negedge clk);
    n_checks++;
    if (t >= 300) begin n_fail++; $display("FAIL wait_idle u=%0d still busy after 300 cycles, want idle", u); end
  endtask

  task automatic test_reset();
    in_valid = 2'b00;
    for (int u = 0; u < 2; u++) begin in_data[u] = '0; in_len[u] = '0; lerr_cnt[u] = 0; idle_bad[u] = 0; end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (in_ready !== 2'b00) begin n_fail++; $display("FAIL reset_ready got %b want 00", in_ready); end
    reset = 1'b1;
    #1;
    for (int u = 0; u < 2; u++) begin
      n_checks++;
      if ({in_ready[u], busy[u], dout[u], dout_valid[u], done[u], len_err[u]} !== {1'b1, 1'b0, idle_lv[u], 3'b000}) begin
        n_fail++;
        $display("FAIL reset_outputs u=%0d got rdy%b busy%b dout%b dv%b done%b err%b want rdy1 busy0 dout%b dv0 done0 err0",
                 u, in_ready[u], busy[u], dout[u], dout_valid[u], done[u], len_err[u], idle_lv[u]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_single();
    int acc;
    clear_all(0);
    send(0, 8'h16, 5, acc);
    model_word(8'h16, 5);
    wait_idle(0);
    n_checks++;
    if (obs.size() != 5) begin n_fail++; $display("FAIL single_count got %0d want 5", obs.size()); end
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (obs[i].b !== exp_q[i].b || obs[i].d !== exp_q[i].d || obs[i].cyc != acc + 1 + i) begin
        n_fail++;
        $display("FAIL single_bit%0d got b%b d%b cyc%0d want b%b d%b cyc%0d", i, obs[i].b, obs[i].d, obs[i].cyc,
                 exp_q[i].b, exp_q[i].d, acc + 1 + i);
      end
    end
  endtask

  task automatic test_stream();
    int a0, a1;
    clear_all(0);
    send(0, 8'hA5, 8, a0); model_word(8'hA5, 8);
    send(0, 8'h03, 2, a1); model_word(8'h03, 2);
    wait_idle(0);
    n_checks++;
    if (a1 != a0 + 1 || obs.size() != 10) begin
      n_fail++; $display("FAIL stream_accept got gap%0d bits%0d want gap1 bits10", a1 - a0, obs.size());
    end
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (obs[i].b !== exp_q[i].b || obs[i].d !== exp_q[i].d || obs[i].cyc != a0 + 1 + i) begin
        n_fail++;
        $display("FAIL stream_bit%0d got b%b d%b cyc%0d want b%b d%b cyc%0d", i, obs[i].b, obs[i].d, obs[i].cyc,
                 exp_q[i].b, exp_q[i].d, a0 + 1 + i);
      end
    end
  endtask

  task automatic test_gap();
    int a0, a1, want;
    logic [WIDTH-1:0] d0, d1;
    clear_all(1);
    d0 = WIDTH'($urandom_range(0, 7)); d1 = WIDTH'($urandom_range(0, 7));
    send(1, d0, 3, a0); model_word(d0, 3);
    send(1, d1, 3, a1); model_word(d1, 3);
    wait_idle(1);
    n_checks++;
    if (obs.size() != 6 || idle_bad[1] != 0) begin
      n_fail++; $display("FAIL gap_shape got bits%0d idle_bad%0d want bits6 idle_bad0", obs.size(), idle_bad[1]);
    end
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
      want = a0 + 1 + i + ((i >= 3) ? GAP1 : 0);
      n_checks++;
      if (obs[i].b !== exp_q[i].b || obs[i].d !== exp_q[i].d || obs[i].cyc != want) begin
        n_fail++;
        $display("FAIL gap_bit%0d got b%b d%b cyc%0d want b%b d%b cyc%0d", i, obs[i].b, obs[i].d, obs[i].cyc,
                 exp_q[i].b, exp_q[i].d, want);
      end
    end
  endtask

  task automatic test_backpressure();
    int acc [3];
    logic [WIDTH-1:0] d;
    clear_all(0);
    for (int w = 0; w < 3; w++) begin
      d = WIDTH'($urandom);
      send(0, d, 8, acc[w]);
      model_word(d, 8);
    end
    wait_idle(0);
    n_checks++;
    if (obs.size() != 24 || acc[1] != acc[0] + 1 || acc[2] != acc[0] + 9) begin
      n_fail++;
      $display("FAIL bp_accept got bits%0d acc1+%0d acc2+%0d want bits24 acc1+1 acc2+9", obs.size(),
               acc[1] - acc[0], acc[2] - acc[0]);
    end
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (obs[i].b !== exp_q[i].b || obs[i].d !== exp_q[i].d || obs[i].cyc != acc[0] + 1 + i) begin
        n_fail++;
        $display("FAIL bp_bit%0d got b%b d%b cyc%0d want b%b d%b cyc%0d", i, obs[i].b, obs[i].d, obs[i].cyc,
                 exp_q[i].b, exp_q[i].d, acc[0] + 1 + i);
      end
    end
  endtask

  task automatic test_illegal();
    int acc, l;
    logic [WIDTH-1:0] d;
    clear_all(0);
    d = WIDTH'($urandom); send(0, d, 0, acc); model_word(d, 0);
    d = WIDTH'($urandom); send(0, d, 9, acc); model_word(d, 9);
    d = WIDTH'($urandom); l = $urandom_range(1, WIDTH);
    send(0, d, l, acc); model_word(d, l);
    wait_idle(0);
    n_checks++;
    if (lerr_cnt[0] != 2 || obs.size() != l || idle_bad[0] != 0) begin
      n_fail++;
      $display("FAIL illegal_shape got err%0d bits%0d idle_bad%0d want err2 bits%0d idle_bad0", lerr_cnt[0],
               obs.size(), idle_bad[0], l);
    end
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (obs[i].b !== exp_q[i].b || obs[i].d !== exp_q[i].d || obs[i].cyc != acc + 1 + i) begin
        n_fail++;
        $display("FAIL illegal_bit%0d got b%b d%b cyc%0d want b%b d%b cyc%0d", i, obs[i].b, obs[i].d, obs[i].cyc,
                 exp_q[i].b, exp_q[i].d, acc + 1 + i);
      end
    end
  endtask

  task automatic test_reset_mid();
    int acc, t;
    clear_all(0);
    send(0, WIDTH'($urandom), 8, acc);
    send(0, WIDTH'($urandom), 8, acc);
    t = 0;
    do begin @(negedge clk); #1; t++; end while (obs.size() < 3 && t < 40);
    reset = 1'b0;
    #1;
    n_checks++;
    if ({dout_valid[0], busy[0], dout[0], done[0], in_ready[0]} !== 5'b00000) begin
      n_fail++;
      $display("FAIL midreset_async got dv%b busy%b dout%b done%b rdy%b want all 0", dout_valid[0], busy[0],
               dout[0], done[0], in_ready[0]);
    end
    @(negedge clk);
    reset = 1'b1;
    obs.delete();
    repeat (20) @(negedge clk);
    #1;
    n_checks++;
    if (obs.size() != 0 || in_ready[0] !== 1'b1 || busy[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_after got bits%0d rdy%b busy%b want bits0 rdy1 busy0", obs.size(), in_ready[0], busy[0]);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    int acc, l, gap_min;
    logic [WIDTH-1:0] d;
    for (int u = 0; u < 2; u++) begin
      clear_all(u);
      gap_min = (u == 0) ? 1 : GAP1 + 1;
      for (int n = 0; n < 25; n++) begin
        repeat ($urandom_range(0, 3)) begin
          in_data[u] = WIDTH'($urandom); in_len[u] = LW'($urandom);
          @(negedge clk);
        end
        d = WIDTH'($urandom);
        if ($urandom_range(0, 9) == 0) l = $urandom_range(0, 1) ? 0 : $urandom_range(WIDTH + 1, 15);
        else                           l = $urandom_range(1, WIDTH);
        send(u, d, l, acc);
        model_word(d, l);
      end
      wait_idle(u);
      n_checks++;
      if (obs.size() != exp_q.size() || lerr_cnt[u] != exp_err || idle_bad[u] != 0) begin
        n_fail++;
        $display("FAIL rand_totals u=%0d got bits%0d err%0d idle_bad%0d want bits%0d err%0d idle_bad0", u,
                 obs.size(), lerr_cnt[u], idle_bad[u], exp_q.size(), exp_err);
      end
      for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
        n_checks++;
        if (obs[i].b !== exp_q[i].b || obs[i].d !== exp_q[i].d ||
            (i > 0 && !obs[i-1].d && obs[i].cyc != obs[i-1].cyc + 1) ||
            (i > 0 && obs[i-1].d && obs[i].cyc < obs[i-1].cyc + gap_min)) begin
          n_fail++;
          $display("FAIL rand_bit u=%0d i=%0d got b%b d%b cyc%0d want b%b d%b (prev cyc%0d)", u, i, obs[i].b,
                   obs[i].d, obs[i].cyc, exp_q[i].b, exp_q[i].d, (i > 0) ? obs[i-1].cyc : -1);
        end
      end
    end
  endtask

  initial begin
    in_valid = 2'b00;
    test_reset();
    test_single();
    test_stream();
    test_gap();
    test_backpressure();
    test_illegal();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
